// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, funct codes, FSM states
// and the EX/MEM register layout.
package ex_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_SLT   = 3'b100,
    ALU_NOR   = 3'b101,
    ALU_MUL   = 3'b110,
    ALU_RTYPE = 3'b111
  } alu_op_e;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_MUL = 6'h18;

  // Bit positions inside the EX control group.
  localparam int EX_REGDST  = 4;
  localparam int EX_ALUSRC  = 3;
  localparam int EX_ALUOP_H = 2;
  localparam int EX_ALUOP_L = 0;

  localparam logic [1:0] WB_BUBBLE = 2'b00;
  localparam logic [2:0] M_BUBBLE  = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ex_state_e;

  // Fully decoded operation, after resolving R-type funct.
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_NOR, OP_MUL, OP_NONE
  } op_e;

  typedef struct packed {
    logic [DATA_W-1:0] branch_tgt;
    logic              zero;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] wdata;
    logic [4:0]        wreg;
    logic [1:0]        wb;
    logic [2:0]        m;
  } exmem_t;

  function automatic op_e decode_op(input alu_op_e alu_op, input logic [5:0] funct);
    case (alu_op)
      ALU_ADD: return OP_ADD;
      ALU_SUB: return OP_SUB;
      ALU_AND: return OP_AND;
      ALU_OR:  return OP_OR;
      ALU_SLT: return OP_SLT;
      ALU_NOR: return OP_NOR;
      ALU_MUL: return OP_MUL;
      default: begin
        case (funct)
          FN_ADD:  return OP_ADD;
          FN_SUB:  return OP_SUB;
          FN_AND:  return OP_AND;
          FN_OR:   return OP_OR;
          FN_NOR:  return OP_NOR;
          FN_SLT:  return OP_SLT;
          FN_MUL:  return OP_MUL;
          default: return OP_NONE;
        endcase
      end
    endcase
  endfunction

endpackage

// File: rtl/mult_iterativo.sv
// Shift-add multiplier: one partial product per cycle, W steps, low W bits kept.
module mult_iterativo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic         i_abort,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_product
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_busy;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_a    <= i_a;
      r_b    <= i_b;
      r_acc  <= '0;
    end else if (r_busy) begin
      if (r_b[0]) r_acc <= r_acc + r_a;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt + CW'(1);
      if (o_done) r_busy <= 1'b0;
    end
  end

  // High during the cycle whose edge performs the final step.
  assign o_done    = r_busy && (r_cnt == CW'(W - 1));
  assign o_busy    = r_busy;
  assign o_product = r_acc;

endmodule

// File: rtl/etapa_ex_mem.sv
// Execute stage with EX/MEM pipeline register; MUL runs on an iterative
// multiplier and stalls upstream until its product is registered.
module etapa_ex_mem
  import ex_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [31:0] pc4_i,
  input  logic [31:0] rd1_i,
  input  logic [31:0] rd2_i,
  input  logic [31:0] sx_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [1:0]  wb_i,
  input  logic [2:0]  m_i,
  input  logic [4:0]  ex_i,
  output logic [31:0] branch_tgt_o,
  output logic        zero_o,
  output logic [31:0] alu_res_o,
  output logic [31:0] wdata_o,
  output logic [4:0]  wreg_o,
  output logic [1:0]  wb_o,
  output logic [2:0]  m_o,
  output logic        stall_o
);

  ex_state_e   r_state;
  ex_state_e   w_next_state;
  exmem_t      r_exmem;
  exmem_t      w_exmem_next;
  op_e         w_op;
  logic        w_is_mul;
  logic [31:0] w_op_b;
  logic [31:0] w_alu_res;
  logic [31:0] w_result;
  logic        w_stall;
  logic        w_mul_start;
  logic        w_mul_busy;
  logic        w_mul_done;
  logic [31:0] w_mul_product;

  assign w_op     = decode_op(alu_op_e'(ex_i[EX_ALUOP_H:EX_ALUOP_L]), sx_i[5:0]);
  assign w_is_mul = (w_op == OP_MUL);
  assign w_op_b   = ex_i[EX_ALUSRC] ? sx_i : rd2_i;

  // NOTE: default assignment first keeps this block purely combinational.
  always_comb begin
    w_alu_res = '0;
    case (w_op)
      OP_ADD:  w_alu_res = rd1_i + w_op_b;
      OP_SUB:  w_alu_res = rd1_i - w_op_b;
      OP_AND:  w_alu_res = rd1_i & w_op_b;
      OP_OR:   w_alu_res = rd1_i | w_op_b;
      OP_NOR:  w_alu_res = ~(rd1_i | w_op_b);
      OP_SLT:  w_alu_res = {31'b0, $signed(rd1_i) < $signed(w_op_b)};
      default: w_alu_res = '0;
    endcase
  end

  mult_iterativo #(.W(MUL_CYCLES)) u_mult (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_mul_start),
    .i_abort   (flush_i),
    .i_a       (rd1_i),
    .i_b       (w_op_b),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (flush_i) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_is_mul) w_next_state = ST_BUSY;
        ST_BUSY: begin
          if (w_mul_done)       w_next_state = ST_DONE;
          else if (!w_mul_busy) w_next_state = ST_IDLE;  // multiplier lost its job
        end
        ST_DONE: w_next_state = ST_IDLE;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_stall     = 1'b0;
    w_mul_start = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_mul && !flush_i) begin
            w_stall     = 1'b1;
            w_mul_start = 1'b1;
          end
        end
        ST_BUSY: w_stall = 1'b1;
        default: w_stall = 1'b0;
      endcase
    end
  end

  // At DONE the held ID/EX inputs still describe the MUL, so wreg/wb/m/rd2 come straight from them.
  assign w_result = (r_state == ST_DONE) ? w_mul_product : w_alu_res;

  always_comb begin
    w_exmem_next    = '0;
    w_exmem_next.wb = WB_BUBBLE;
    w_exmem_next.m  = M_BUBBLE;
    if (!(flush_i || w_stall)) begin
      w_exmem_next.branch_tgt = pc4_i + {sx_i[29:0], 2'b00};
      w_exmem_next.zero       = (w_result == '0);
      w_exmem_next.alu_res    = w_result;
      w_exmem_next.wdata      = rd2_i;
      w_exmem_next.wreg       = ex_i[EX_REGDST] ? rd_i : rt_i;
      w_exmem_next.wb         = wb_i;
      w_exmem_next.m          = m_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_exmem <= '0;
    else     r_exmem <= w_exmem_next;
  end

  assign branch_tgt_o = r_exmem.branch_tgt;
  assign zero_o       = r_exmem.zero;
  assign alu_res_o    = r_exmem.alu_res;
  assign wdata_o      = r_exmem.wdata;
  assign wreg_o       = r_exmem.wreg;
  assign wb_o         = r_exmem.wb;
  assign m_o          = r_exmem.m;
  assign stall_o      = w_stall;

endmodule

// File: tb/tb_etapa_ex_mem.sv
// Scoreboard bench for etapa_ex_mem: the driver queues the expected EX/MEM
// contents for every edge and a monitor compares them after each edge.
module tb_etapa_ex_mem;

  logic        clk = 1'b0;
  logic        rst, flush_i;
  logic [31:0] pc4_i, rd1_i, rd2_i, sx_i;
  logic [4:0]  rt_i, rd_i, ex_i;
  logic [1:0]  wb_i;
  logic [2:0]  m_i;
  logic [31:0] branch_tgt_o, alu_res_o, wdata_o;
  logic        zero_o, stall_o;
  logic [4:0]  wreg_o;
  logic [1:0]  wb_o;
  logic [2:0]  m_o;

  typedef struct packed {
    logic [31:0] bt;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  wreg;
    logic [1:0]  wb;
    logic [2:0]  m;
  } exp_t;

  localparam exp_t BUBBLE = '0;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   sb_idx   = 0;

  etapa_ex_mem #(.MUL_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .pc4_i(pc4_i), .rd1_i(rd1_i),
    .rd2_i(rd2_i), .sx_i(sx_i), .rt_i(rt_i), .rd_i(rd_i), .wb_i(wb_i), .m_i(m_i),
    .ex_i(ex_i), .branch_tgt_o(branch_tgt_o), .zero_o(zero_o), .alu_res_o(alu_res_o),
    .wdata_o(wdata_o), .wreg_o(wreg_o), .wb_o(wb_o), .m_o(m_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: one expected EX/MEM image per edge.
  initial begin
    exp_t e, g;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        g = '{branch_tgt_o, zero_o, alu_res_o, wdata_o, wreg_o, wb_o, m_o};
        n_checks++;
        if (g !== e) begin
          n_errors++;
          $display("FAIL sb#%0d: got bt=%h z=%b alu=%h wd=%h wr=%0d wb=%b m=%b expected bt=%h z=%b alu=%h wd=%h wr=%0d wb=%b m=%b",
                   sb_idx, g.bt, g.zero, g.alu, g.wdata, g.wreg, g.wb, g.m,
                   e.bt, e.zero, e.alu, e.wdata, e.wreg, e.wb, e.m);
        end
        sb_idx++;
      end
    end
  end

  // Inputs are already set (at a falling edge); check stall, queue expectation, advance.
  task automatic step(input exp_t e, input logic e_stall);
    #1;
    check("stall_o", {31'b0, stall_o}, {31'b0, e_stall});
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic set_in(input logic [31:0] pc4, rd1, rd2, sx, input logic [4:0] rt, rd,
                        input logic [1:0] wb, input logic [2:0] m, input logic [4:0] ex);
    pc4_i = pc4; rd1_i = rd1; rd2_i = rd2; sx_i = sx; rt_i = rt; rd_i = rd;
    wb_i = wb; m_i = m; ex_i = ex;
  endtask

  function automatic exp_t mk(input logic [31:0] bt, alu, wd, input logic [4:0] wr,
                              input logic [1:0] wb, input logic [2:0] m);
    return '{bt, (alu == 32'h0), alu, wd, wr, wb, m};
  endfunction

  task automatic vec(input logic [31:0] pc4, rd1, rd2, sx, input logic [4:0] rt, rd,
                     input logic [1:0] wb, input logic [2:0] m, input logic [4:0] ex,
                     input logic [31:0] e_bt, e_alu, input logic [4:0] e_wreg);
    set_in(pc4, rd1, rd2, sx, rt, rd, wb, m, ex);
    step(mk(e_bt, e_alu, rd2, e_wreg, wb, m), 1'b0);
  endtask

  // MUL: 33 stalled bubble cycles, then the product on the DONE cycle.
  task automatic mul_run(input logic [31:0] pc4, rd1, rd2, sx, input logic [4:0] rt, rd,
                         input logic [1:0] wb, input logic [2:0] m, input logic [4:0] ex,
                         input logic [31:0] e_bt, e_prod, input logic [4:0] e_wreg);
    set_in(pc4, rd1, rd2, sx, rt, rd, wb, m, ex);
    for (int i = 0; i < 33; i++) step(BUBBLE, 1'b1);
    step(mk(e_bt, e_prod, rd2, e_wreg, wb, m), 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_in($urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
             2'($urandom), 3'($urandom), 5'($urandom));
      step(BUBBLE, 1'b0);
    end
    rst = 1'b0;

    //   pc4           rd1           rd2           sx            rt  rd  wb     m       ex         bt            alu           wreg
    vec(32'h40,       32'd5,        32'd7,        32'h20,       4,  3,  2'b11, 3'b010, 5'b10111, 32'hC0,       32'd12,       3);
    vec(32'h200,      32'd10,       32'h55,       32'hFFFFFFFE, 9,  1,  2'b10, 3'b001, 5'b01000, 32'h1F8,      32'd8,        9);
    vec(32'h100,      32'd4,        32'd4,        32'd3,        2,  7,  2'b00, 3'b100, 5'b00001, 32'h10C,      32'd0,        2);
    vec(32'h0,        32'hFFFFFFFF, 32'd1,        32'd0,        5,  6,  2'b01, 3'b000, 5'b00100, 32'h0,        32'd1,        5);
    vec(32'h20,       32'd1,        32'hFFFFFFFF, 32'h2A,       1,  2,  2'b01, 3'b000, 5'b10111, 32'hC8,       32'd0,        2);
    vec(32'h4,        32'hFF00FF00, 32'h0FF00FF0, 32'd0,        11, 12, 2'b01, 3'b000, 5'b00010, 32'h4,        32'h0F000F00, 11);
    vec(32'h4,        32'hFF00FF00, 32'h0FF00FF0, 32'd0,        11, 12, 2'b01, 3'b000, 5'b00011, 32'h4,        32'hFFF0FFF0, 11);
    vec(32'h10,       32'hF0F0F0F0, 32'h0F0F0F00, 32'd0,        6,  7,  2'b01, 3'b000, 5'b00101, 32'h10,       32'h0000000F, 6);
    vec(32'h0,        32'd3,        32'd5,        32'h22,       0,  13, 2'b01, 3'b000, 5'b10111, 32'h88,       32'hFFFFFFFE, 13);
    vec(32'h0,        32'd1,        32'd2,        32'h3F,       0,  8,  2'b01, 3'b000, 5'b10111, 32'hFC,       32'd0,        8);
    vec(32'h1000,     32'd0,        32'd0,        32'h27,       0,  14, 2'b01, 3'b000, 5'b10111, 32'h109C,     32'hFFFFFFFF, 14);
    vec(32'h0,        32'hC,        32'hA,        32'h24,       0,  15, 2'b01, 3'b000, 5'b10111, 32'h90,       32'h8,        15);
    vec(32'h0,        32'hC,        32'hA,        32'h25,       0,  16, 2'b01, 3'b000, 5'b10111, 32'h94,       32'hE,        16);
    vec(32'h0,        32'd0,        32'h99,       32'd1,        17, 0,  2'b01, 3'b000, 5'b01001, 32'h4,        32'hFFFFFFFF, 17);
    vec(32'hFFFFFFFC, 32'hFFFFFFFF, 32'd1,        32'd1,        18, 0,  2'b01, 3'b000, 5'b00000, 32'h0,        32'd0,        18);

    // Flush on an ordinary instruction: bubble, no stall.
    flush_i = 1'b1;
    set_in(32'h0, 32'd1, 32'd1, 32'd0, 21, 0, 2'b11, 3'b111, 5'b00000);
    step(BUBBLE, 1'b0);
    flush_i = 1'b0;

    // Back-to-back MULs (ALUOp 110, then R-type funct 0x18), then a zero product.
    mul_run(32'h400, 32'd6,        32'd7, 32'h10, 1,  4,  2'b11, 3'b000, 5'b10110, 32'h440, 32'd42,       4);
    mul_run(32'h800, 32'hFFFFFFFF, 32'd2, 32'h18, 1,  10, 2'b10, 3'b101, 5'b10111, 32'h860, 32'hFFFFFFFE, 10);
    mul_run(32'h8,   32'd5,        32'd0, 32'd0,  19, 0,  2'b01, 3'b000, 5'b00110, 32'h8,   32'd0,        19);

    // Flush at BUSY cycle 10: the aborted MUL must never write back.
    set_in(32'h0, 32'd6, 32'd7, 32'd0, 22, 0, 2'b11, 3'b010, 5'b00110);
    for (int i = 0; i < 10; i++) step(BUBBLE, 1'b1);
    flush_i = 1'b1;
    step(BUBBLE, 1'b1);
    flush_i = 1'b0;
    for (int i = 0; i < 36; i++) vec(32'h0, 32'd1, 32'd1, 32'd0, 20, 0, 2'b01, 3'b000, 5'b00000, 32'h0, 32'd2, 20);

    // Reset mid-MUL.
    set_in(32'h0, 32'd6, 32'd7, 32'd0, 23, 0, 2'b11, 3'b010, 5'b00110);
    for (int i = 0; i < 5; i++) step(BUBBLE, 1'b1);
    rst = 1'b1; flush_i = 1'b1;
    step(BUBBLE, 1'b0);
    rst = 1'b0; flush_i = 1'b0;
    for (int i = 0; i < 36; i++) vec(32'h0, 32'd3, 32'd4, 32'd0, 24, 0, 2'b10, 3'b001, 5'b00000, 32'h0, 32'd7, 24);

    // Drain the scoreboard with a bounded wait.
    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/etapa_ex_mem.md
Name: etapa_ex_mem

Overview:
- Execute stage plus EX/MEM pipeline register, directly downstream of the ID/EX buffer.
- Consumes the ID/EX outputs: PC+4, rs/rt data, sign-extended immediate, rt/rd fields, and the WB/M/EX control groups.
- Performs ALU operation, destination-register select, branch-target add, and an iterative 32-cycle multiply that stalls the pipeline.
- Registers results for the MEM stage.

Parameters:
- MUL_CYCLES, 32, number of shift-add iterations for MUL (must equal data width).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush_i  in  1  squash this cycle's EX instruction; abort any multiply.
- pc4_i  in  32  PC+4 from ID/EX.
- rd1_i  in  32  rs data.
- rd2_i  in  32  rt data.
- sx_i  in  32  sign-extended immediate; [5:0] is funct for R-type.
- rt_i  in  5  rt field.
- rd_i  in  5  rd field.
- wb_i  in  2  WB control, passed through.
- m_i  in  3  MEM control, passed through.
- ex_i  in  5  EX control: [4]=RegDst, [3]=ALUSrc, [2:0]=ALUOp.
- branch_tgt_o  out  32  registered pc4 + (sx<<2).
- zero_o  out  1  registered (ALU result == 0).
- alu_res_o  out  32  registered ALU/MUL result.
- wdata_o  out  32  registered rd2 (store data).
- wreg_o  out  5  registered destination register.
- wb_o  out  2  registered WB control.
- m_o  out  3  registered MEM control.
- stall_o  out  1  combinational; high means upstream must hold ID/EX and earlier stages.

Behaviour:
- Reset: all outputs 0, FSM IDLE, counter 0. rst has priority over flush_i.
- Operand B = ALUSrc ? sx_i : rd2_i. wreg = RegDst ? rd_i : rt_i.
- ALUOp encoding:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT (signed, result 0/1), 101 NOR, 110 MUL.
  - 111 R-type, decoded by funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT, 0x18 MUL.
  - Unknown funct gives result 0; register write still occurs.
- Arithmetic is 32-bit, wrap-around, no overflow trap. MUL keeps the low 32 bits of the unsigned product.
- Branch target = pc4_i + {sx_i[29:0],2'b00}, wrapping.
- Non-MUL instructions: 1-cycle latency. EX/MEM loads every cycle in which stall_o=0.
- MUL FSM:
  - IDLE: is_mul and !flush_i → stall_o=1, capture operands, counter 0, go to BUSY. EX/MEM loads a bubble (wb=0, m=0, other fields don't-care but zeroed).
  - BUSY: stall_o=1, one shift-add step per cycle. After MUL_CYCLES steps go to DONE. EX/MEM loads a bubble each cycle.
  - DONE: stall_o=0. EX/MEM loads the product plus the held wreg/wb/m/rd2. Next state is IDLE unconditionally; the held MUL is not restarted.
- MUL presented at cycle T: stall_o high T..T+32 (33 cycles); result visible on outputs at T+34.
- Upstream obligation: ID/EX inputs stay stable while stall_o=1. The block relies on this to recover wreg/wb/m at DONE.
- flush_i=1 in any state: next edge EX/MEM loads a bubble and FSM goes to IDLE (MUL aborted, no write). stall_o still follows current state that cycle.
- Back-to-back MULs: the second begins in the IDLE cycle after DONE.

Decomposition:
- Package ex_pkg:
  - ALUOp codes and funct codes.
  - FSM state enum IDLE/BUSY/DONE.
  - EX-field bit positions.
  - Bubble constants for WB/M.
- One sub-module: mult_iterativo, the shift-add multiplier with start/busy/done, 32-bit operands and low-32 product.
- ALU stays combinational inside etapa_ex_mem.

Test Plan:
- Reset: rst high 2 cycles with random inputs → all outputs 0, stall_o 0.
- R-type ADD: rd1=5, rd2=7, funct 0x20, ex=5'b1_0_111, rd=3 → next cycle alu_res=12, wreg=3, wb/m passed through.
- Immediate ADD: rd1=10, sx=0xFFFFFFFE, ex=5'b0_1_000, rt=9 → alu_res=8, wreg=9.
- Branch compare: rd1=rd2=4, SUB, pc4=0x100, sx=3 → zero=1, branch_tgt=0x10C.
- SLT signed: rd1=0xFFFFFFFF, rd2=1 → alu_res=1.
- MUL: rd1=6, rd2=7 held → stall_o high exactly 33 cycles, bubbles (wb=0, m=0) meanwhile, then alu_res=42.
  - Repeat with 0xFFFFFFFF×2 → 0xFFFFFFFE.
- Flush mid-MUL: assert flush_i at BUSY cycle 10 → bubble, FSM IDLE, no MUL result ever written.
  - Repeat with rst mid-MUL → all outputs 0.
